// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding 32-bit access against a combinational-read
// RAM. Sub-word stores use a read-modify-write of the enclosing word; loads
// extract and extend the addressed byte/half lane (little-endian).

// One byte lane of the RMW merge: take the new byte when selected, else keep the old one.
module lsu_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  state_t   state;
  lsu_req_t req;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        acc_err;
  logic [31:0] lane_word;
  logic [31:0] load_ext;
  logic [NUM_LANES-1:0] lane_en;
  logic [31:0] wdata_rep;
  logic [31:0] merged;

  // Misalignment / illegal width detection on the incoming request.
  always_comb begin
    acc_err = 1'b0;
    if (cpu_we) begin
      case (cpu_funct3)
        3'd0:    acc_err = 1'b0;
        3'd1:    acc_err = cpu_addr[0];
        3'd2:    acc_err = (cpu_addr[1:0] != 2'b00);
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (cpu_funct3)
        3'd0, 3'd4: acc_err = 1'b0;
        3'd1, 3'd5: acc_err = cpu_addr[0];
        3'd2:       acc_err = (cpu_addr[1:0] != 2'b00);
        default:    acc_err = 1'b1;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0; halves are aligned so addr[0]=0.
  assign lane_word = ram_rdata >> {req.addr[1:0], 3'b000};

  // Sign/zero extension of the extracted lane.
  always_comb begin
    case (req.funct3)
      3'd0:    load_ext = {{24{lane_word[7]}},  lane_word[7:0]};
      3'd1:    load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'd2:    load_ext = lane_word;
      3'd4:    load_ext = {24'h0, lane_word[7:0]};
      3'd5:    load_ext = {16'h0, lane_word[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  // Byte enables for sub-word stores (SB: one lane, SH: two adjacent lanes).
  always_comb begin
    lane_en = '0;
    if (req.funct3[1:0] == 2'd0) begin
      lane_en[req.addr[1:0]] = 1'b1;
    end else begin
      lane_en[{req.addr[1], 1'b0}] = 1'b1;
      lane_en[{req.addr[1], 1'b1}] = 1'b1;
    end
  end

  // Replicate store data so every candidate lane sees the right bits.
  assign wdata_rep = (req.funct3[1:0] == 2'd0) ? {4{req.wdata[7:0]}}
                                                : {2{req.wdata[15:0]}};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lsu_byte_lane u_lane (
      .sel      (lane_en[k]),
      .old_byte (merge_q[8*k +: 8]),
      .new_byte (wdata_rep[8*k +: 8]),
      .merged   (merged[8*k +: 8])
    );
  end

  // Control FSM; request fields, merge word and results are latched here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      req     <= '0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req) begin
          req     <= '{we: cpu_we, funct3: cpu_funct3, addr: cpu_addr, wdata: cpu_wdata};
          rdata_q <= 32'h0;
          err_q   <= acc_err;
          if (acc_err)                 state <= S_DONE;
          else if (!cpu_we)            state <= S_LOAD;
          else if (cpu_funct3 == 3'd2) state <= S_STORE;
          else                         state <= S_RMW_RD;
        end
        S_LOAD: begin
          rdata_q <= load_ext;
          state   <= S_DONE;
        end
        S_STORE:  state <= S_DONE;
        S_RMW_RD: begin
          merge_q <= ram_rdata;
          state   <= S_RMW_WR;
        end
        S_RMW_WR: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode straight from the state register so an async reset
  // kills an in-flight write before the edge that would commit it.
  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    case (state)
      S_LOAD, S_RMW_RD: begin
        ram_read = 1'b1;
        ram_addr = {req.addr[31:2], 2'b00};
      end
      S_STORE: begin
        ram_write = 1'b1;
        ram_addr  = {req.addr[31:2], 2'b00};
        ram_wdata = req.wdata;
      end
      S_RMW_WR: begin
        ram_write = 1'b1;
        ram_addr  = {req.addr[31:2], 2'b00};
        ram_wdata = merged;
      end
      default: ;
    endcase
  end

  assign cpu_ready = (state == S_IDLE);
  assign cpu_done  = (state == S_DONE);
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;

endmodule
